// File: rtl/chip_result_tx.sv
// chip_result_tx: byte-serial transmitter that returns 128-bit AES result blocks
// over a 9-bit link (shakehand + tx[7:0]).
// Each 128-bit block is sent as 16 bytes, MSB byte first.
// Each byte is announced by one toggle of shakehand, framed by SETUP/HOLD windows.
// A GAP of idle cycles follows the last byte of each block.
// Optional feature: define CHIP_RESULT_TX_CHECKSUM_EN to append a 17th byte,
// the XOR of the 16 data bytes.
module chip_result_tx #(
  parameter int unsigned SETUP = 2,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned GAP   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic         data_valid,
  output logic         data_ready,
  output logic         shakehand,
  output logic [7:0]   tx,
  output logic         busy
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BCNT_W = 5;

  localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP - 1);

  // Index of the final byte of a block; with the checksum it is one past the data
  localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(15);
`ifdef CHIP_RESULT_TX_CHECKSUM_EN
  localparam logic [BCNT_W-1:0] LAST = BCNT_W'(16);
`else
  localparam logic [BCNT_W-1:0] LAST = LAST_DATA;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HOLD  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BCNT_W-1:0]  bcnt;
  logic [127:0]       sr;
`ifdef CHIP_RESULT_TX_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  // Framing FSM: loads a block, steps through bytes, toggles shakehand, idles for GAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      sr         <= '0;
      tx         <= '0;
      shakehand  <= 1'b0;
      data_ready <= 1'b1;
      busy       <= 1'b0;
`ifdef CHIP_RESULT_TX_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (data_valid && data_ready) begin
            sr         <= data_in;
            tx         <= data_in[127:120];
            bcnt       <= '0;
            cnt        <= '0;
            data_ready <= 1'b0;
            busy       <= 1'b1;
`ifdef CHIP_RESULT_TX_CHECKSUM_EN
            csum       <= '0;
`endif
            state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (cnt == SETUP_END) begin
            shakehand <= ~shakehand;
            cnt       <= '0;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (cnt == HOLD_END) begin
            cnt <= '0;
            if (bcnt == LAST) begin
              state <= S_GAP;
            end else begin
              bcnt  <= bcnt + BCNT_W'(1);
              state <= S_SETUP;
`ifdef CHIP_RESULT_TX_CHECKSUM_EN
              // After the last data byte, send the running XOR folded with that byte
              if (bcnt == LAST_DATA) begin
                tx <= csum ^ sr[127:120];
              end else begin
                csum <= csum ^ sr[127:120];
                sr   <= sr << 8;
                tx   <= sr[119:112];
              end
`else
              sr <= sr << 8;
              tx <= sr[119:112];
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt == GAP_END) begin
            cnt        <= '0;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip_result_tx.sv
// Bench for chip_result_tx: one default-parameter instance and one 1/1/1 instance.
// A receiver-style monitor pops expected bytes from a scoreboard queue on each
// shakehand edge. It also checks the setup/hold windows, the toggle spacing,
// the block latency and the back-to-back block period.
module tb_chip_result_tx;

`ifdef CHIP_RESULT_TX_CHECKSUM_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  localparam int D_SETUP = 2;
  localparam int D_HOLD  = 4;
  localparam int D_GAP   = 8;
  localparam int M_SETUP = 1;
  localparam int M_HOLD  = 1;
  localparam int M_GAP   = 1;
  localparam int MAXW    = 400;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;

  logic [127:0] d_data;
  logic         d_valid, d_ready, d_sh, d_busy;
  logic [7:0]   d_tx;
  logic [127:0] m_data;
  logic         m_valid, m_ready, m_sh, m_busy;
  logic [7:0]   m_tx;

  logic         mon_ready, mon_sh, mon_busy;
  logic [7:0]   mon_tx;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [7:0]  exp_q[$];
  int          blk_toggles = 0;
  bit          check_period = 1'b0;

  chip_result_tx #(.SETUP(D_SETUP), .HOLD(D_HOLD), .GAP(D_GAP)) dut (
    .clk(clk), .rst(rst), .data_in(d_data), .data_valid(d_valid),
    .data_ready(d_ready), .shakehand(d_sh), .tx(d_tx), .busy(d_busy)
  );

  chip_result_tx #(.SETUP(M_SETUP), .HOLD(M_HOLD), .GAP(M_GAP)) dut_min (
    .clk(clk), .rst(rst), .data_in(m_data), .data_valid(m_valid),
    .data_ready(m_ready), .shakehand(m_sh), .tx(m_tx), .busy(m_busy)
  );

  assign mon_ready = sel ? m_ready : d_ready;
  assign mon_sh    = sel ? m_sh    : d_sh;
  assign mon_busy  = sel ? m_busy  : d_busy;
  assign mon_tx    = sel ? m_tx    : d_tx;

  always #5 clk = ~clk;

  // Posedge counter used for latency and spacing measurements
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests = n_tests + 1;
    if (got != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue the bytes a receiver must see for one block, checksum included if built in
  task automatic push_block(input logic [127:0] b);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      exp_q.push_back(b[i*8 +: 8]);
      x = x ^ b[i*8 +: 8];
    end
    if (NB == 17) exp_q.push_back(x);
  endtask

  // Offer a block to the selected instance and return one cycle after acceptance
  task automatic send(input logic [127:0] b, input bit hold);
    int t;
    if (sel) begin m_data = b; m_valid = 1'b1; end
    else     begin d_data = b; d_valid = 1'b1; end
    t = 0;
    while (!mon_ready && t < MAXW) begin
      @(negedge clk); #1;
      t++;
    end
    check("ready_wait", int'(mon_ready), 1);
    push_block(b);
    @(negedge clk); #1;
    check("accepted", int'(mon_ready), 0);
    if (!hold) begin m_valid = 1'b0; d_valid = 1'b0; end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!mon_ready && t < MAXW) begin
      @(negedge clk); #1;
      t++;
    end
    check("idle_wait", int'(mon_ready), 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_toggles(input int n);
    int t;
    t = 0;
    while (blk_toggles < n && t < MAXW) begin
      @(negedge clk); #1;
      t++;
    end
    check("reach_byte", blk_toggles, n);
  endtask

  // Receiver model: samples at negedge, acts on shakehand edges and ready transitions
  initial begin
    logic       prev_sh, prev_ready, start_sh;
    logic [7:0] prev_tx;
    int since_change, since_toggle, last_tog, acc_cyc, s, h, g;
    bit have_acc;
    prev_sh = 1'b0; prev_ready = 1'b1; prev_tx = 8'h00; start_sh = 1'b0;
    since_change = 0; since_toggle = 100; last_tog = 0; acc_cyc = 0; have_acc = 1'b0;
    forever begin
      @(negedge clk);
      s = sel ? M_SETUP : D_SETUP;
      h = sel ? M_HOLD  : D_HOLD;
      g = sel ? M_GAP   : D_GAP;
      if (rst) begin
        prev_sh = mon_sh; prev_tx = mon_tx; prev_ready = mon_ready;
        since_change = 100; since_toggle = 100; blk_toggles = 0; have_acc = 1'b0;
      end else begin
        since_change++;
        since_toggle++;
        if (mon_tx != prev_tx) begin
          check("hold_window", int'(since_toggle >= h), 1);
          since_change = 0;
        end
        if (mon_sh != prev_sh) begin
          check("setup_window", int'(since_change >= s), 1);
          if (blk_toggles > 0) check("toggle_spacing", cyc - last_tog, s + h);
          last_tog = cyc;
          since_toggle = 0;
          blk_toggles++;
          if (exp_q.size() == 0) check("byte_underflow", exp_q.size(), 1);
          else check($sformatf("byte_%0d", blk_toggles - 1), int'(mon_tx), int'(exp_q.pop_front()));
        end
        if (!mon_ready && prev_ready) begin
          if (check_period && have_acc) check("block_period", cyc - acc_cyc, NB*(s+h) + g + 1);
          check("busy_on_accept", int'(mon_busy), 1);
          acc_cyc = cyc;
          have_acc = 1'b1;
          blk_toggles = 0;
          start_sh = mon_sh;
        end
        if (mon_ready && !prev_ready) begin
          check("ready_latency", cyc - acc_cyc, NB*(s+h) + g);
          check("toggles_per_block", blk_toggles, NB);
          check("sh_parity", int'(mon_sh), int'(start_sh) ^ (NB % 2));
          check("busy_on_idle", int'(mon_busy), 0);
        end
        prev_sh = mon_sh; prev_tx = mon_tx; prev_ready = mon_ready;
      end
    end
  end

  // Stimulus
  initial begin
    sel = 1'b0; rst = 1'b1;
    d_data = '0; d_valid = 1'b0; m_data = '0; m_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_ready",  int'(d_ready), 1);
    check("rst_sh",     int'(d_sh),    0);
    check("rst_tx",     int'(d_tx),    0);
    check("rst_busy",   int'(d_busy),  0);
    check("rst_ready_min", int'(m_ready), 1);
    check("rst_tx_min",    int'(m_tx),    0);

    // Single block at default framing
    send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0);
    wait_idle();

    // Back-to-back with data_valid held
    send(128'hdeadbeef_01234567_89abcdef_a5a55a5a, 1'b1);
    check_period = 1'b1;
    send(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1'b0);
    wait_idle();
    check_period = 1'b0;

    // Reset asynchronously while byte 7 is on the bus
    send(128'h01234567_89abcdef_fedcba98_76543210, 1'b0);
    wait_toggles(7);
    repeat (4) @(negedge clk);
    #2;
    check("byte7_on_tx", int'(d_tx), 'hef);
    rst = 1'b1;
    #1;
    check("async_rst_ready", int'(d_ready), 1);
    check("async_rst_sh",    int'(d_sh),    0);
    check("async_rst_tx",    int'(d_tx),    0);
    check("async_rst_busy",  int'(d_busy),  0);
    check("bytes_dropped",   exp_q.size(),  NB - 7);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    send({4{32'hffffffff}}, 1'b0);
    check("sh_start_after_rst", int'(d_sh), 0);
    wait_idle();

    // Minimum framing 1/1/1, back-to-back
    @(negedge clk);
    #2 rst = 1'b1; sel = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
    check_period = 1'b1;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_idle();
    check_period = 1'b0;

`ifdef CHIP_RESULT_TX_CHECKSUM_EN
    // Checksum byte for a known vector; tx keeps the last byte afterwards
    @(negedge clk);
    #2 rst = 1'b1; sel = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); #1;
    send(128'h01020304_05060708_090a0b0c_0d0e0f10, 1'b0);
    wait_idle();
    check("checksum_byte", int'(d_tx), 'h10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chip_result_tx.md
# chip_result_tx

Chip-side byte-serial transmitter that returns AES result blocks to the verification platform over the 9-bit link: `shakehand` plus an 8-bit `tx` bus. It accepts one 128-bit block through a valid/ready handshake and sends it as 16 bytes, MSB byte first. Each byte is announced by a toggle of `shakehand`, framed by programmable setup and hold windows so a receiver in an unrelated clock domain can sample safely. It sits between the AES core output and the chip pads.

## Interface
- `SETUP`, default 2: cycles `tx` is stable before each `shakehand` toggle; legal range 1..255.
- `HOLD`, default 4: cycles `tx` is held after each toggle; legal range 1..255.
- `GAP`, default 8: idle cycles after the last byte of a block; legal range 1..255.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `data_in`  input  128  result block; bits [127:120] are sent first.
- `data_valid`  input  1  `data_in` is valid.
- `data_ready`  output  1  block can be accepted this cycle (IDLE only).
- `shakehand`  output  1  toggles once per byte.
- `tx`  output  8  current byte.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, SETUP, HOLD, GAP. It uses an 8-bit cycle counter `cnt`, a 5-bit byte counter `bcnt` and a 128-bit shift register `sr`.
- **IDLE**
  - `data_ready`=1.
  - On `data_valid & data_ready`: `sr`←`data_in`, `tx`←`data_in[127:120]`, `bcnt`←0, `cnt`←0, go to SETUP.
- **SETUP**
  - `cnt` increments each cycle.
  - When `cnt==SETUP-1`: `shakehand`←~`shakehand`, `cnt`←0, go to HOLD.
- **HOLD**
  - `cnt` increments each cycle.
  - When `cnt==HOLD-1` and `bcnt==LAST`: `cnt`←0, go to GAP.
  - When `cnt==HOLD-1` otherwise: `sr`←`sr<<8`, `tx`←next byte, `bcnt`++, `cnt`←0, go to SETUP.
- **GAP**
  - When `cnt==GAP-1`: go to IDLE.
- `LAST`=15, or 16 with the checksum byte compiled in.
- `tx` changes only on entry to SETUP, never during HOLD or GAP. It keeps the last byte until the next block loads.
- `data_valid` is ignored while `busy`. The upstream source holds `data_valid` and `data_in` until it sees `data_ready`.
- `shakehand` is never reset between blocks; receivers detect edges, not levels.
- Reset mid-block aborts the block immediately. Outputs take their reset values, the partially sent block is lost and no resume is attempted.

## Timing
- Reset values:
  - `data_ready`=1
  - `shakehand`=0
  - `tx`=8'h00
  - `busy`=0
  - state IDLE, all counters 0
- Accept at edge k. The first byte is on `tx` from edge k.
- Byte n (0-based):
  - `tx` valid from edge k+n·(SETUP+HOLD).
  - `shakehand` toggles at edge k+n·(SETUP+HOLD)+SETUP.
- GAP is entered at edge k+N·(SETUP+HOLD), where N=16, or 17 with the checksum.
- IDLE and `data_ready`=1 return at edge k+N·(SETUP+HOLD)+GAP.
  - Defaults: 104 cycles, or 110 with the checksum.
- If `data_valid` is held, back-to-back accept occurs in the first IDLE cycle. Block period is therefore N·(SETUP+HOLD)+GAP+1.
- Minimum settings (1/1/1): 2 cycles per byte.

## Configuration
- Macro `CHIP_RESULT_TX_CHECKSUM_EN`.
- Defined: a 17th byte is appended after byte 15. Its value is the XOR of the 16 data bytes, sent with the same SETUP/HOLD framing and toggle. `shakehand` ends each block inverted relative to its start.
- Undefined: exactly 16 bytes per block, with no checksum logic or register.

## Test plan
- Reset: assert `rst` asynchronously between clock edges → outputs `data_ready`=1, `shakehand`=0, `tx`=00, `busy`=0 immediately.
- Single block, defaults, `data_in`=128'h00112233_44556677_8899aabb_ccddeeff:
  - Receiver captures 00,11,…,ff on 16 `shakehand` edges.
  - Each byte is stable ≥2 cycles before and ≥4 cycles after its edge.
  - `data_ready` rises exactly 104 cycles after accept.
- Back-to-back: `data_valid` held high with two different blocks → second accepted in the first IDLE cycle; block period 105 cycles; no byte lost or duplicated.
- Minimum parameters SETUP=HOLD=GAP=1 → a toggle every 2 cycles; block done in 33 cycles; data correct.
- Reset during byte 7 → outputs reset at once. A subsequent block 128'hffff…ff is sent complete with 16 toggles starting from `shakehand`=0.
- With `CHIP_RESULT_TX_CHECKSUM_EN`, `data_in`=128'h01020304_05060708_090a0b0c_0d0e0f10 → 17th byte = 8'h10; 17 toggles; `data_ready` returns after 110 cycles.
